// File: rtl/mem_writer_arbiter.sv
// mem_writer_arbiter: shares one mem_writer between NUM_CLIENTS requesters, round-robin.
// A grant is held for a whole request -> data -> response transaction; data paths are combinational.
//
// state | meaning
// IDLE  | no grant; arbitrate among cl_req_vld, starting at rr_ptr
// REQ   | forward the granted client's request to mem_writer
// DATA  | forward the granted client's data beats until last
// RESP  | return the mem_writer response to the granted client
module mem_writer_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ID_W        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CLIENTS*32-1:0] cl_req_data,
  input  logic [NUM_CLIENTS-1:0]    cl_req_vld,
  output logic [NUM_CLIENTS-1:0]    cl_req_rdy,
  input  logic [NUM_CLIENTS*49-1:0] cl_data_data,
  input  logic [NUM_CLIENTS-1:0]    cl_data_vld,
  output logic [NUM_CLIENTS-1:0]    cl_data_rdy,
  output logic [NUM_CLIENTS-1:0]    cl_resp_data,
  output logic [NUM_CLIENTS-1:0]    cl_resp_vld,
  input  logic [NUM_CLIENTS-1:0]    cl_resp_rdy,
  output logic [31:0]               mw_req_data,
  output logic                      mw_req_vld,
  input  logic                      mw_req_rdy,
  output logic [48:0]               mw_data_data,
  output logic                      mw_data_vld,
  input  logic                      mw_data_rdy,
  input  logic                      mw_resp_data,
  input  logic                      mw_resp_vld,
  output logic                      mw_resp_rdy,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  logic [ID_W-1:0] cand, pick;
  logic            any_req;

  // First requester at or above rr_ptr, wrapping at NUM_CLIENTS.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_CLIENTS);
      if (!any_req && cl_req_vld[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
    rr_nxt = (pick == ID_W'(NUM_CLIENTS - 1)) ? '0 : pick + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        grant_id <= pick;
        rr_ptr   <= rr_nxt;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cl_req_rdy   = '0;
    cl_data_rdy  = '0;
    cl_resp_vld  = '0;
    cl_resp_data = '0;
    mw_req_data  = cl_req_data[32*grant_id +: 32];
    mw_req_vld   = 1'b0;
    mw_data_data = cl_data_data[49*grant_id +: 49];
    mw_data_vld  = 1'b0;
    mw_resp_rdy  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = REQ;
      end
      REQ: begin
        mw_req_vld           = cl_req_vld[grant_id];
        cl_req_rdy[grant_id] = mw_req_rdy;
        // zero-length requests skip straight to the response
        if (mw_req_vld && mw_req_rdy)
          state_nxt = (mw_req_data[15:0] == 16'd0) ? RESP : DATA;
      end
      DATA: begin
        mw_data_vld           = cl_data_vld[grant_id];
        cl_data_rdy[grant_id] = mw_data_rdy;
        if (mw_data_vld && mw_data_rdy && mw_data_data[0]) state_nxt = RESP;
      end
      RESP: begin
        cl_resp_vld[grant_id]  = mw_resp_vld;
        cl_resp_data[grant_id] = mw_resp_data;
        mw_resp_rdy            = cl_resp_rdy[grant_id];
        if (mw_resp_vld && mw_resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_writer_arbiter.sv
// tb_mem_writer_arbiter: randomized client/mem_writer stimulus checked against a transaction-level
// round-robin model; each scenario task compares the recorded transcript with the model's.
module tb_mem_writer_arbiter;
  localparam int NC = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC*32-1:0] cl_req_data;
  logic [NC-1:0]   cl_req_vld, cl_req_rdy;
  logic [NC*49-1:0] cl_data_data;
  logic [NC-1:0]   cl_data_vld, cl_data_rdy;
  logic [NC-1:0]   cl_resp_data, cl_resp_vld, cl_resp_rdy;
  logic [31:0]     mw_req_data;
  logic            mw_req_vld, mw_req_rdy;
  logic [48:0]     mw_data_data;
  logic            mw_data_vld, mw_data_rdy;
  logic            mw_resp_data, mw_resp_vld, mw_resp_rdy;
  logic            busy;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  mem_writer_arbiter #(.NUM_CLIENTS(NC), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cl_req_data(cl_req_data), .cl_req_vld(cl_req_vld), .cl_req_rdy(cl_req_rdy),
    .cl_data_data(cl_data_data), .cl_data_vld(cl_data_vld), .cl_data_rdy(cl_data_rdy),
    .cl_resp_data(cl_resp_data), .cl_resp_vld(cl_resp_vld), .cl_resp_rdy(cl_resp_rdy),
    .mw_req_data(mw_req_data), .mw_req_vld(mw_req_vld), .mw_req_rdy(mw_req_rdy),
    .mw_data_data(mw_data_data), .mw_data_vld(mw_data_vld), .mw_data_rdy(mw_data_rdy),
    .mw_resp_data(mw_resp_data), .mw_resp_vld(mw_resp_vld), .mw_resp_rdy(mw_resp_rdy),
    .busy(busy), .grant_id(grant_id)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // drive-side queues (what each client still has to offer) and model-side copies
  logic [31:0] req_q[NC][$];
  logic [48:0] beat_q[NC][$];
  logic [31:0] mdl_req[NC][$];
  int          mdl_nb[NC][$];
  logic [48:0] mdl_beat[NC][$];
  int          mdl_rr;
  logic        mw_pend[$];
  logic        resp_sent[$];
  logic [63:0] log_q[$], exp_q[$];
  int          grant_log[$], exp_grant[$];

  int   mw_pct, data_pct, resp_pct, resp_force;
  bit   toggle_mode;
  int   hold[NC];
  int   iso_viol, gid_viol, dvld_cycles, resp0_cycles;
  logic busy_after_resp;
  bit   after_resp;
  logic prev_busy;
  logic [IW-1:0] prev_gid;

  task automatic push_txn(input int c, input logic [31:0] req, input int nb);
    req_q[c].push_back(req);
    mdl_req[c].push_back(req);
    mdl_nb[c].push_back(nb);
  endtask

  task automatic push_beat(input int c, input logic [48:0] beat);
    beat_q[c].push_back(beat);
    mdl_beat[c].push_back(beat);
  endtask

  task automatic rand_txn(input int c);
    int nb;
    logic [15:0] len;
    len = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(255, 1));
    nb  = (len == 16'd0) ? 0 : int'($urandom_range(4, 1));
    push_txn(c, {16'($urandom), len}, nb);
    for (int i = 0; i < nb; i++) push_beat(c, {$urandom, 16'($urandom_range(64, 1)), (i == nb - 1)});
  endtask

  task automatic flush();
    for (int c = 0; c < NC; c++) begin
      req_q[c].delete(); beat_q[c].delete();
      mdl_req[c].delete(); mdl_nb[c].delete(); mdl_beat[c].delete();
      hold[c] = 0;
    end
    mw_pend.delete();
  endtask

  task automatic clear_logs();
    log_q.delete(); exp_q.delete(); resp_sent.delete(); grant_log.delete(); exp_grant.delete();
    iso_viol = 0; gid_viol = 0; dvld_cycles = 0; resp0_cycles = 0;
    after_resp = 0; busy_after_resp = 1'b1;
  endtask

  task automatic zero_inputs();
    cl_req_vld = '0; cl_data_vld = '0; cl_resp_rdy = '0;
    cl_req_data = '0; cl_data_data = '0;
    mw_req_rdy = 1'b0; mw_data_rdy = 1'b0; mw_resp_vld = 1'b0; mw_resp_data = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    flush();
    mdl_rr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_busy = 1'b0;
    prev_gid = '0;
  endtask

  task automatic mw_gen();
    logic b;
    b = (resp_force < 0) ? 1'($urandom_range(1)) : 1'(resp_force);
    mw_pend.push_back(b);
    resp_sent.push_back(b);
  endtask

  // One clock: drive at the falling edge, sample 1ns later, record the handshakes the next rising edge takes.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NC; c++) begin
      cl_req_vld[c] = (req_q[c].size() > 0);
      cl_req_data[32*c +: 32] = cl_req_vld[c] ? req_q[c][0] : $urandom;
      cl_data_vld[c] = (beat_q[c].size() > 0);
      cl_data_data[49*c +: 49] = cl_data_vld[c] ? beat_q[c][0] : {$urandom, 17'($urandom)};
      cl_resp_rdy[c] = (hold[c] == 0) && ($urandom_range(99) < resp_pct);
    end
    mw_req_rdy   = ($urandom_range(99) < mw_pct);
    mw_data_rdy  = toggle_mode ? ((cyc % 2) == 1) : ($urandom_range(99) < data_pct);
    mw_resp_vld  = (mw_pend.size() > 0);
    mw_resp_data = mw_resp_vld ? mw_pend[0] : 1'($urandom);
    #1;
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    if (after_resp) begin busy_after_resp = busy; after_resp = 0; end
    for (int c = 0; c < NC; c++)
      if ((!busy || c != int'(grant_id)) && (cl_req_rdy[c] || cl_data_rdy[c] || cl_resp_vld[c])) iso_viol++;
    if (!busy && (mw_req_vld || mw_data_vld || mw_resp_rdy)) iso_viol++;
    if (busy && prev_busy && grant_id != prev_gid) gid_viol++;
    if (mw_data_vld) dvld_cycles++;
    if (cl_resp_vld[0]) resp0_cycles++;
    if (mw_req_vld && mw_req_rdy) begin
      log_q.push_back({4'h1, 4'(grant_id), 7'b0, 17'b0, mw_req_data});
      if (mw_req_data[15:0] == 16'd0) mw_gen();
    end
    if (mw_data_vld && mw_data_rdy) begin
      log_q.push_back({4'h2, 4'(grant_id), 7'b0, mw_data_data});
      if (mw_data_data[0]) mw_gen();
    end
    if (mw_resp_vld && mw_resp_rdy) void'(mw_pend.pop_front());
    for (int c = 0; c < NC; c++) begin
      if (cl_req_vld[c] && cl_req_rdy[c]) void'(req_q[c].pop_front());
      if (cl_data_vld[c] && cl_data_rdy[c]) void'(beat_q[c].pop_front());
      if (cl_resp_vld[c] && cl_resp_rdy[c]) begin
        log_q.push_back({4'h3, 4'(c), 55'b0, cl_resp_data[c]});
        after_resp = 1;
      end
      if (cl_resp_vld[c] && hold[c] > 0) hold[c]--;
    end
    prev_busy = busy;
    prev_gid  = grant_id;
  endtask

  task automatic run_txns(input int budget, output bit ok);
    int n;
    bit pending;
    n = 0; ok = 0;
    while (!ok && n < budget) begin
      step();
      n++;
      pending = (mw_pend.size() > 0) || busy;
      for (int c = 0; c < NC; c++) if (req_q[c].size() > 0) pending = 1;
      ok = !pending;
    end
  endtask

  // Transaction-level model: every queued request is pending, so grants rotate over clients with work left.
  task automatic model_build();
    int g, k;
    logic rb;
    k = 0;
    exp_q.delete(); exp_grant.delete();
    forever begin
      g = -1;
      for (int j = 0; j < NC; j++)
        if (g < 0 && mdl_req[(mdl_rr + j) % NC].size() > 0) g = (mdl_rr + j) % NC;
      if (g < 0) break;
      exp_grant.push_back(g);
      mdl_rr = (g + 1) % NC;
      exp_q.push_back({4'h1, 4'(g), 7'b0, 49'(mdl_req[g].pop_front())});
      repeat (mdl_nb[g].pop_front()) exp_q.push_back({4'h2, 4'(g), 7'b0, mdl_beat[g].pop_front()});
      rb = (k < resp_sent.size()) ? resp_sent[k] : 1'b0;
      exp_q.push_back({4'h3, 4'(g), 55'b0, rb});
      k++;
    end
  endtask

  task automatic set_rates(input int m, input int d, input int r, input int f);
    mw_pct = m; data_pct = d; resp_pct = r; resp_force = f; toggle_mode = 0;
  endtask

  task automatic test_reset();
    logic [3*NC+2:0] outs;
    rst = 1'b1;
    cl_req_vld = '1; cl_data_vld = '1; cl_resp_rdy = '1;
    mw_req_rdy = 1'b1; mw_data_rdy = 1'b1; mw_resp_vld = 1'b1;
    @(posedge clk); #1;
    outs = {cl_req_rdy, cl_data_rdy, cl_resp_vld, mw_req_vld, mw_data_vld, mw_resp_rdy};
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else passed++;
    checks++; if (grant_id !== '0) $display("FAIL reset_grant got %0d required 0", grant_id); else passed++;
    checks++; if (outs !== '0) $display("FAIL reset_handshake got %b required 0", outs); else passed++;
    @(negedge clk);
    zero_inputs();
    rst = 1'b0;
    @(negedge clk); #1;
    outs = {cl_req_rdy, cl_data_rdy, cl_resp_vld, mw_req_vld, mw_data_vld, mw_resp_rdy};
    checks++; if ({busy, outs} !== '0) $display("FAIL reset_idle got %b required 0", {busy, outs}); else passed++;
  endtask

  task automatic test_single();
    bit ok;
    do_reset(); clear_logs();
    set_rates(100, 100, 100, 1);
    push_txn(0, {16'h0100, 16'd8}, 2);
    push_beat(0, {32'hAABBCCDD, 16'd4, 1'b0});
    push_beat(0, {32'h11223344, 16'd4, 1'b1});
    run_txns(100, ok);
    model_build();
    checks++; if (!ok) $display("FAIL single_timeout got busy required idle"); else passed++;
    checks++; if (log_q.size() != exp_q.size()) $display("FAIL single_count got %0d required %0d", log_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) begin
      checks++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
      else $display("FAIL single_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
    end
    checks++; if (busy_after_resp !== 1'b0) $display("FAIL single_busy_fall got %b required 0", busy_after_resp); else passed++;
  endtask

  task automatic test_same_cycle();
    bit ok;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      set_rates(80, 80, 80, -1);
      rand_txn(0); rand_txn(1);
      run_txns(300, ok);
      model_build();
      checks++; if (!ok) $display("FAIL same_cycle_timeout round %0d got busy required idle", r); else passed++;
      checks++; if (grant_log.size() != exp_grant.size()) $display("FAIL same_cycle_grants got %0d required %0d", grant_log.size(), exp_grant.size()); else passed++;
      foreach (exp_grant[i]) begin
        checks++;
        if (i < grant_log.size() && grant_log[i] == exp_grant[i]) passed++;
        else $display("FAIL same_cycle_order[%0d] round %0d got %0d required %0d", i, r, (i < grant_log.size()) ? grant_log[i] : -1, exp_grant[i]);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
        else $display("FAIL same_cycle_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_logs();
    set_rates(100, 100, 100, -1);
    push_txn(1, {16'h0200, 16'd0}, 0);
    run_txns(100, ok);
    model_build();
    checks++; if (!ok) $display("FAIL zero_len_timeout got busy required idle"); else passed++;
    checks++; if (dvld_cycles != 0) $display("FAIL zero_len_data_vld got %0d cycles required 0", dvld_cycles); else passed++;
    checks++; if (log_q.size() != exp_q.size()) $display("FAIL zero_len_count got %0d required %0d", log_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) begin
      checks++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
      else $display("FAIL zero_len_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    set_rates(100, 0, 100, -1);
    toggle_mode = 1;
    hold[0] = 5;
    push_txn(0, {16'h0400, 16'd12}, 4);
    for (int i = 0; i < 4; i++) push_beat(0, {$urandom, 16'd4, (i == 3)});
    run_txns(200, ok);
    model_build();
    checks++; if (!ok) $display("FAIL backpressure_timeout got busy required idle"); else passed++;
    checks++; if (gid_viol != 0) $display("FAIL backpressure_grant_change got %0d required 0", gid_viol); else passed++;
    checks++; if (resp0_cycles != 6) $display("FAIL backpressure_resp_hold got %0d cycles required 6", resp0_cycles); else passed++;
    checks++; if (log_q.size() != exp_q.size()) $display("FAIL backpressure_count got %0d required %0d", log_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) begin
      checks++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
      else $display("FAIL backpressure_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
    end
    toggle_mode = 0;
  endtask

  task automatic test_isolation();
    bit ok;
    clear_logs();
    set_rates(70, 70, 70, -1);
    push_txn(0, {16'h0500, 16'd3}, 3);
    for (int i = 0; i < 3; i++) push_beat(0, {$urandom, 16'd1, (i == 2)});
    for (int i = 0; i < 3; i++) beat_q[1].push_back({$urandom, 16'd7, (i == 2)});
    run_txns(200, ok);
    model_build();
    checks++; if (!ok) $display("FAIL isolation_timeout got busy required idle"); else passed++;
    checks++; if (iso_viol != 0) $display("FAIL isolation_ungranted got %0d cycles required 0", iso_viol); else passed++;
    checks++; if (beat_q[1].size() != 3) $display("FAIL isolation_client1_beats got %0d left required 3", beat_q[1].size()); else passed++;
    checks++; if (log_q.size() != exp_q.size()) $display("FAIL isolation_count got %0d required %0d", log_q.size(), exp_q.size()); else passed++;
    foreach (exp_q[i]) begin
      checks++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
      else $display("FAIL isolation_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
    end
    beat_q[1].delete();
  endtask

  task automatic test_rst_mid();
    bit ok;
    int n;
    logic [3*NC+3:0] outs;
    clear_logs();
    set_rates(100, 0, 100, -1);
    push_txn(0, {16'h0300, 16'd16}, 4);
    for (int i = 0; i < 4; i++) push_beat(0, {$urandom, 16'd4, (i == 3)});
    n = 0;
    while (dvld_cycles == 0 && n < 20) begin step(); n++; end
    checks++; if (mw_data_vld !== 1'b1) $display("FAIL rst_mid_pre_data got %b required 1", mw_data_vld); else passed++;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    outs = {cl_req_rdy, cl_data_rdy, cl_resp_vld, mw_req_vld, mw_data_vld, mw_resp_rdy, busy};
    checks++; if (outs !== '0) $display("FAIL rst_mid_async got %b required 0", outs); else passed++;
    flush(); clear_logs(); zero_inputs();
    mdl_rr = 0;
    @(negedge clk);
    rst = 1'b0;
    prev_busy = 1'b0;
    set_rates(100, 100, 100, -1);
    rand_txn(1); rand_txn(0);
    run_txns(300, ok);
    model_build();
    checks++; if (!ok) $display("FAIL rst_mid_timeout got busy required idle"); else passed++;
    foreach (exp_grant[i]) begin
      checks++;
      if (i < grant_log.size() && grant_log[i] == exp_grant[i]) passed++;
      else $display("FAIL rst_mid_order[%0d] got %0d required %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_grant[i]);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
      else $display("FAIL rst_mid_xact[%0d] got %h required %h", i, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int r = 0; r < 10; r++) begin
      clear_logs();
      set_rates(int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), -1);
      for (int c = 0; c < NC; c++) begin
        n = (r == 0) ? ((c == 0) ? 3 : 0) : int'($urandom_range(4));
        repeat (n) rand_txn(c);
      end
      run_txns(3000, ok);
      model_build();
      checks++; if (!ok) $display("FAIL random_timeout round %0d got busy required idle", r); else passed++;
      checks++; if (iso_viol != 0 || gid_viol != 0) $display("FAIL random_grant_rules round %0d got %0d/%0d required 0/0", r, iso_viol, gid_viol); else passed++;
      checks++; if (grant_log.size() != exp_grant.size()) $display("FAIL random_grants round %0d got %0d required %0d", r, grant_log.size(), exp_grant.size()); else passed++;
      foreach (exp_grant[i]) begin
        checks++;
        if (i < grant_log.size() && grant_log[i] == exp_grant[i]) passed++;
        else $display("FAIL random_order[%0d] round %0d got %0d required %0d", i, r, (i < grant_log.size()) ? grant_log[i] : -1, exp_grant[i]);
      end
      checks++; if (log_q.size() != exp_q.size()) $display("FAIL random_count round %0d got %0d required %0d", r, log_q.size(), exp_q.size()); else passed++;
      foreach (exp_q[i]) begin
        checks++;
        if (i < log_q.size() && log_q[i] === exp_q[i]) passed++;
        else $display("FAIL random_xact[%0d] round %0d got %h required %h", i, r, (i < log_q.size()) ? log_q[i] : 64'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    flush();
    clear_logs();
    mdl_rr = 0;
    prev_busy = 1'b0;
    prev_gid = '0;
    set_rates(100, 100, 100, -1);
    test_reset();
    test_single();
    test_same_cycle();
    test_zero_len();
    test_backpressure();
    test_isolation();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
